// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin front end for a single-port sync-write/async-read RAM.
// Clears the whole RAM after reset, then serves one registered command per cycle.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              init_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              rr;   // 1: requester 1 wins a tie
  logic              elig0, elig1, win0, win1;

  // A request already being granted is still visible for one cycle; mask it.
  always_comb begin
    elig0 = req0 & ~gnt0;
    elig1 = req1 & ~gnt1;
    win0  = elig0 & (~elig1 | ~rr);
    win1  = elig1 & (~elig0 | rr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      cnt       <= '0;
      rr        <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      init_done <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;

      // The command on the RAM port this cycle belongs to whoever holds gnt.
      if (!ram_we && (gnt0 || gnt1)) begin
        rdata   <= ram_dout;
        rvalid0 <= gnt0;
        rvalid1 <= gnt1;
      end

      case (state)
        ST_CLEAR: begin
          ram_we   <= 1'b1;
          ram_addr <= cnt;
          ram_din  <= CLEAR_VAL;
          cnt      <= cnt + ADDR_W'(1);
          if (&cnt) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (win0) begin
            ram_we   <= we0;
            ram_addr <= addr0;
            ram_din  <= wdata0;
            gnt0     <= 1'b1;
            rr       <= 1'b1;
          end else if (win1) begin
            ram_we   <= we1;
            ram_addr <= addr1;
            ram_din  <= wdata1;
            gnt1     <= 1'b1;
            rr       <= 1'b0;
          end else begin
            ram_we <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 256x8 RAM on its RAM port.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, init_done, ram_we;
  logic [7:0] rdata, ram_addr, ram_din, ram_dout;
  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .CLEAR_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .init_done(init_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  typedef struct {
    logic       r0, w0; logic [7:0] a0, d0;
    logic       r1, w1; logic [7:0] a1, d1;
    logic       g0, g1, v0, v1, crd; logic [7:0] rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [7:0] a0,
                              input logic [7:0] d0, input logic r1, input logic w1,
                              input logic [7:0] a1, input logic [7:0] d1,
                              input logic g0, input logic g1, input logic v0,
                              input logic v1, input logic crd, input logic [7:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.crd = crd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'({gnt0, gnt1}), 32'd0);
    chk({tag, "_rvalid"}, 32'({rvalid0, rvalid1}), 32'd0);
    chk({tag, "_rdata"},  32'(rdata), 32'd0);
    chk({tag, "_init"},   32'(init_done), 32'd0);
    chk({tag, "_ramwe"},  32'(ram_we), 32'd0);
    chk({tag, "_ramadr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ramdin"}, 32'(ram_din), 32'd0);
  endtask

  // Called right after rst release (at a negedge); ends in the first RUN cycle.
  task automatic clear_check();
    for (int k = 1; k <= 256; k++) begin
      step();
      chk("clr_we",   32'(ram_we), 32'd1);
      chk("clr_addr", 32'(ram_addr), 32'(k - 1));
      chk("clr_din",  32'(ram_din), 32'd0);
      chk("clr_gnt",  32'({gnt0, gnt1}), 32'd0);
      chk("clr_init", 32'(init_done), 32'(k == 256));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    idle();
    rst = 1'b1;
    #1;
    chk_all_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");

    // Reset in the middle of the clear sequence.
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= 129; k++) step();
    chk("t5_addr80", 32'(ram_addr), 32'h80);
    rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    @(negedge clk) rst = 1'b0;
    clear_check();

    //    r0 w0 a0     d0     r1 w1 a1     d1     g0 g1 v0 v1 crd rd
    vq.push_back(mk(1, 1, 8'h3C, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00));
    vq.push_back(mk(1, 1, 8'h3C, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h77, 8'h00, 0, 0, 1, 0, 1, 8'hA5));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h77, 8'h00, 0, 1, 0, 0, 1, 8'hA5));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h00));
    vq.push_back(mk(1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 0, 0, 0, 0, 1, 8'h00));
    vq.push_back(mk(1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 1, 0, 0, 0, 1, 8'h00));
    vq.push_back(mk(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 0, 1, 8'h00));
    vq.push_back(mk(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 0, 1, 8'h00));
    vq.push_back(mk(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 1, 0, 1, 8'h11));
    vq.push_back(mk(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 1, 1, 8'h22));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 1, 8'h11));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h22));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5A, 0, 0, 0, 0, 1, 8'h22));
    vq.push_back(mk(1, 0, 8'h10, 8'h00, 1, 1, 8'h10, 8'h5A, 0, 1, 0, 0, 1, 8'h22));
    vq.push_back(mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h22));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h5A));
    vq.push_back(mk(1, 1, 8'h50, 8'h99, 1, 1, 8'h50, 8'h77, 0, 0, 0, 0, 1, 8'h5A));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h50, 8'h77, 0, 1, 0, 0, 1, 8'h5A));
    vq.push_back(mk(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h5A));
    vq.push_back(mk(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h5A));
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h77));

    foreach (vq[i]) begin
      step();
      chk($sformatf("v%0d_gnt0", i),   32'(gnt0), 32'(vq[i].g0));
      chk($sformatf("v%0d_gnt1", i),   32'(gnt1), 32'(vq[i].g1));
      chk($sformatf("v%0d_rvalid0", i), 32'(rvalid0), 32'(vq[i].v0));
      chk($sformatf("v%0d_rvalid1", i), 32'(rvalid1), 32'(vq[i].v1));
      if (vq[i].crd) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vq[i].rd));
      req0 = vq[i].r0; we0 = vq[i].w0; addr0 = vq[i].a0; wdata0 = vq[i].d0;
      req1 = vq[i].r1; we1 = vq[i].w1; addr1 = vq[i].a1; wdata1 = vq[i].d1;
    end

    // Reset lands while a read by requester 0 is in its grant cycle.
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C;
    step();
    chk("t6_gnt0", 32'(gnt0), 32'd1);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    rst = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    step();
    chk("t6_no_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    chk("t6_init", 32'(init_done), 32'd0);
    @(negedge clk) rst = 1'b0;
    clear_check();
    step();
    chk("t6_first_gnt0", 32'(gnt0), 32'd1);
    chk("t6_first_gnt1", 32'(gnt1), 32'd0);
    step();
    chk("t6_gnt1", 32'(gnt1), 32'd1);
    chk("t6_gnt0_off", 32'(gnt0), 32'd0);
    chk("t6_rvalid0", 32'(rvalid0), 32'd1);
    chk("t6_rdata0", 32'(rdata), 32'h00);
    idle();
    step();
    chk("t6_rvalid1", 32'(rvalid1), 32'd1);
    chk("t6_rdata1", 32'(rdata), 32'h00);
    chk("t6_gnt_end", 32'({gnt0, gnt1}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
